// File: rtl/boxcar_filter_mc.sv
`default_nettype none
// ============================================================================
//  Module      : boxcar_filter_mc
//  Description : Multi-channel, time-multiplexed moving-average (boxcar)
//                filter. Each channel keeps its own circular sample buffer,
//                write pointer, fill count and running sum. One sample per
//                i_ce, tagged with a channel index; window is 2^LOG2_LEN.
//                Optional macro BOXCAR_ROUND_EN selects round-half-up
//                averaging instead of truncation toward -inf.
//  Revision    : 1.0 - initial release
// ============================================================================
module boxcar_filter_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int LOG2_LEN   = 3,
    parameter int NUM_CH     = 4,
    parameter int CH_WIDTH   = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH),
    // Derived running-sum width; a full window of extreme samples fits exactly.
    parameter int ACC_WIDTH  = DATA_WIDTH + LOG2_LEN
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_clear,
    input  logic                  i_ce,
    input  logic [CH_WIDTH-1:0]   i_ch,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ce,
    output logic [CH_WIDTH-1:0]   o_ch,
    output logic [ACC_WIDTH-1:0]  o_sum,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_primed
);

    localparam int                WIN_LEN  = 1 << LOG2_LEN;
    localparam int                MEM_DEPTH = NUM_CH * WIN_LEN;
    localparam logic [LOG2_LEN:0] C_FULL   = (LOG2_LEN + 1)'(WIN_LEN);
    localparam logic [CH_WIDTH:0] C_NUM_CH = (CH_WIDTH + 1)'(NUM_CH);

    // Sample storage: one WIN_LEN-deep ring per channel, address {ch, ptr}.
    logic [DATA_WIDTH-1:0] mem_q  [0:MEM_DEPTH-1];

    // Per-channel bookkeeping.
    logic [LOG2_LEN-1:0]   ptr_q  [NUM_CH];
    logic [LOG2_LEN:0]     fill_q [NUM_CH];
    logic [ACC_WIDTH-1:0]  sum_q  [NUM_CH];

    // Registered outputs.
    logic                  ce_q;
    logic [CH_WIDTH-1:0]   ch_q;
    logic [ACC_WIDTH-1:0]  osum_q;
    logic [DATA_WIDTH-1:0] odata_q;
    logic                  primed_q;

    logic                  w_ch_valid;
    logic                  w_accept;
    logic [CH_WIDTH-1:0]   w_ch_sel;
    logic [CH_WIDTH+LOG2_LEN-1:0] w_addr;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_old;
    logic [ACC_WIDTH-1:0]  sum_d;
    logic [LOG2_LEN:0]     fill_d;
    logic [LOG2_LEN-1:0]   ptr_d;
    logic [DATA_WIDTH-1:0] avg_d;

    // Out-of-range channel indices (non-power-of-2 NUM_CH) are dropped; the
    // selector is forced to channel 0 so array reads stay in bounds.
    assign w_ch_valid = ({1'b0, i_ch} < C_NUM_CH);
    assign w_accept   = i_ce & ~i_clear & w_ch_valid;
    assign w_ch_sel   = w_ch_valid ? i_ch : '0;
    assign w_addr     = {w_ch_sel, ptr_q[w_ch_sel]};

    // Oldest sample leaves the window only once the ring is full; before that
    // the slot holds stale data and is treated as zero padding.
    assign w_full = (fill_q[w_ch_sel] == C_FULL);
    assign w_old  = w_full ? mem_q[w_addr] : '0;

    assign sum_d  = sum_q[w_ch_sel]
                  - {{LOG2_LEN{w_old[DATA_WIDTH-1]}},  w_old}
                  + {{LOG2_LEN{i_data[DATA_WIDTH-1]}}, i_data};
    assign fill_d = w_full ? C_FULL : fill_q[w_ch_sel] + 1'b1;
    assign ptr_d  = ptr_q[w_ch_sel] + 1'b1;

`ifdef BOXCAR_ROUND_EN
    // Adding half an LSB then flooring equals flooring then adding the first
    // discarded bit; this avoids a wider adder and cannot overflow DATA_WIDTH.
    assign avg_d = sum_d[ACC_WIDTH-1:LOG2_LEN]
                 + {{(DATA_WIDTH-1){1'b0}}, sum_d[LOG2_LEN-1]};
`else
    // Dropping the low bits of a two's-complement value truncates toward -inf.
    assign avg_d = sum_d[ACC_WIDTH-1:LOG2_LEN];
`endif

    // Sample ring write; contents are never reset, the fill count masks them.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            mem_q[w_addr] <= i_data;
        end
    end

    // Channel state update and registered output stage.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ptr_q[c]  <= '0;
                fill_q[c] <= '0;
                sum_q[c]  <= '0;
            end
            ce_q     <= 1'b0;
            ch_q     <= '0;
            osum_q   <= '0;
            odata_q  <= '0;
            primed_q <= 1'b0;
        end else if (i_clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ptr_q[c]  <= '0;
                fill_q[c] <= '0;
                sum_q[c]  <= '0;
            end
            ce_q     <= 1'b0;
            ch_q     <= '0;
            osum_q   <= '0;
            odata_q  <= '0;
            primed_q <= 1'b0;
        end else begin
            ce_q <= w_accept;
            if (w_accept) begin
                sum_q[w_ch_sel]  <= sum_d;
                fill_q[w_ch_sel] <= fill_d;
                ptr_q[w_ch_sel]  <= ptr_d;
                ch_q             <= w_ch_sel;
                osum_q           <= sum_d;
                odata_q          <= avg_d;
                primed_q         <= (fill_d == C_FULL);
            end
        end
    end

    assign o_ce     = ce_q;
    assign o_ch     = ch_q;
    assign o_sum    = osum_q;
    assign o_data   = odata_q;
    assign o_primed = primed_q;

endmodule
`default_nettype wire

// File: tb/tb_boxcar_filter_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boxcar_filter_mc
//  Description : Self-checking bench for boxcar_filter_mc. Main instance uses
//                DATA_WIDTH=8, LOG2_LEN=2, NUM_CH=2; a second instance with
//                NUM_CH=3 covers out-of-range channel indices.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boxcar_filter_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clr, ce;
    logic [0:0] ch;
    logic [7:0] din;
    logic       o_ce, o_primed;
    logic [0:0] o_ch;
    logic [9:0] o_sum;
    logic [7:0] o_data;

    logic       clr3, ce3;
    logic [1:0] ch3;
    logic [7:0] din3;
    logic       o_ce3, o_primed3;
    logic [1:0] o_ch3;
    logic [9:0] o_sum3;
    logic [7:0] o_data3;

    boxcar_filter_mc #(.DATA_WIDTH(8), .LOG2_LEN(2), .NUM_CH(2)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr), .i_ce(ce), .i_ch(ch),
        .i_data(din), .o_ce(o_ce), .o_ch(o_ch), .o_sum(o_sum), .o_data(o_data),
        .o_primed(o_primed));

    boxcar_filter_mc #(.DATA_WIDTH(8), .LOG2_LEN(2), .NUM_CH(3)) dut3 (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr3), .i_ce(ce3), .i_ch(ch3),
        .i_data(din3), .o_ce(o_ce3), .o_ch(o_ch3), .o_sum(o_sum3), .o_data(o_data3),
        .o_primed(o_primed3));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int ch; int sum; int avg; int prim; } exp_t;
    typedef struct { logic clr; int ch; int d; int sum; int prim; } vec_t;
    exp_t sbq[$];
    vec_t vecs[$];

    // Average as defined for each build: sum / 4 floored, optionally +0.5 first.
    function automatic int f_avg(input int s);
`ifdef BOXCAR_ROUND_EN
        return (s + 2) >>> 2;
`else
        return s >>> 2;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic c, input int chn, input int d, input int s, input int p);
        vec_t v;
        v.clr = c; v.ch = chn; v.d = d; v.sum = s; v.prim = p;
        vecs.push_back(v);
    endtask

    // One sample per cycle; a clear entry also raises i_ce to show it is dropped.
    task automatic drive(input logic c, input int chn, input int d, input int s, input int p);
        exp_t e;
        @(posedge clk); #1;
        clr = c; ce = 1'b1; ch = chn[0:0]; din = d[7:0];
        if (!c) begin
            e.cyc = cyc + 1; e.ch = chn; e.sum = s; e.avg = f_avg(s); e.prim = p;
            sbq.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        clr = 1'b0; ce = 1'b0;
    endtask

    task automatic step3(input int chn, input int d);
        @(posedge clk); #1;
        ce3 = 1'b1; ch3 = chn[1:0]; din3 = d[7:0];
        @(posedge clk); #1;
        ce3 = 1'b0;
    endtask

    // Scoreboard: every output strobe must match the oldest pending expectation.
    exp_t got;
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_ce) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_o_ce", 1, 0);
                end else begin
                    got = sbq.pop_front();
                    chk("latency",  cyc, got.cyc);
                    chk("o_ch",     int'(o_ch), got.ch);
                    chk("o_sum",    int'($signed(o_sum)), got.sum);
                    chk("o_data",   int'($signed(o_data)), got.avg);
                    chk("o_primed", int'(o_primed), got.prim);
                end
            end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                chk("missing_o_ce", 0, 1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; ce = 1'b0; ch = '0; din = '0;
        clr3 = 1'b0; ce3 = 1'b0; ch3 = '0; din3 = '0;

        // ---- build vector table ----
        add(1, 0, 0, 0, 0);
        add(0, 0, 4, 4, 0);   add(0, 0, 8, 12, 0);  add(0, 0, 12, 24, 0);
        add(0, 0, 16, 40, 1); add(0, 0, 20, 56, 1);
        add(1, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            add(0, 0, 10,   10   * ((k < 4) ? k : 4), (k >= 4) ? 1 : 0);
            add(0, 1, -128, -128 * ((k < 4) ? k : 4), (k >= 4) ? 1 : 0);
        end
        add(1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0);   add(0, 0, 1, 2, 0);   add(0, 0, 1, 3, 0);   add(0, 0, 0, 3, 1);
        add(0, 1, -1, -1, 0); add(0, 1, -1, -2, 0); add(0, 1, -1, -3, 0); add(0, 1, 0, -3, 1);
        add(1, 0, 0, 0, 0);
        add(0, 0, 9, 9, 0);   add(0, 0, 9, 18, 0);  add(0, 0, 9, 27, 0);
        add(1, 0, 9, 0, 0);
        add(0, 0, 5, 5, 0);

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_ce", int'(o_ce), 0);
        chk("rst_o_sum", int'(o_sum), 0);
        chk("rst_o_data", int'(o_data), 0);
        chk("rst_o_primed", int'(o_primed), 0);
        rst_n = 1'b1;

        // ---- asynchronous reset mid-stream ----
        drive(0, 0, 3, 3, 0);
        drive(0, 0, 5, 8, 0);
        @(posedge clk); #3;
        ce = 1'b0;
        chk("pre_rst_o_ce", int'(o_ce), 1);
        chk("pre_rst_o_sum", int'(o_sum), 8);
        rst_n = 1'b0;
        #1;
        chk("async_rst_o_ce", int'(o_ce), 0);
        chk("async_rst_o_ch", int'(o_ch), 0);
        chk("async_rst_o_sum", int'(o_sum), 0);
        chk("async_rst_o_data", int'(o_data), 0);
        chk("async_rst_o_primed", int'(o_primed), 0);
        sbq.delete();
        #2;
        rst_n = 1'b1;
        drive(0, 0, 7, 7, 0);
        idle();

        // ---- table-driven vectors ----
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].ch, vecs[i].d, vecs[i].sum, vecs[i].prim);
        end
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", sbq.size(), 0);

        // ---- out-of-range channel on a 3-channel instance ----
        step3(2, 5);
        chk("ch3_a_o_ce", int'(o_ce3), 1);
        chk("ch3_a_o_sum", int'($signed(o_sum3)), 5);
        step3(0, 3);
        chk("ch3_b_o_sum", int'($signed(o_sum3)), 3);
        step3(3, 100);
        chk("ch3_inv_o_ce", int'(o_ce3), 0);
        chk("ch3_inv_hold_sum", int'($signed(o_sum3)), 3);
        step3(2, 6);
        chk("ch3_c_o_ch", int'(o_ch3), 2);
        chk("ch3_c_o_sum", int'($signed(o_sum3)), 11);
        chk("ch3_c_o_primed", int'(o_primed3), 0);
        step3(0, 4);
        chk("ch3_d_o_sum", int'($signed(o_sum3)), 7);
        step3(2, 7);
        chk("ch3_e_o_sum", int'($signed(o_sum3)), 18);
        step3(2, 8);
        chk("ch3_f_o_sum", int'($signed(o_sum3)), 26);
        chk("ch3_f_o_data", int'($signed(o_data3)), f_avg(26));
        chk("ch3_f_o_primed", int'(o_primed3), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
